// File: rtl/cnvclk_generator_pkg.sv
// Shared definitions for the CNVCLK generator: default width, reset-time
// period/high values and the controller state encoding.
package cnvclk_pkg;
    localparam int CNT_W_DEF  = 16;
    localparam int DEF_PERIOD = 100;
    localparam int DEF_HIGH   = 50;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;
endpackage

// File: rtl/cnvclk_generator_if.sv
// Control/status bundle between the DAQ sequencer (master) and the CNVCLK
// generator (slave).
interface cnvclk_if #(parameter int CNT_W = cnvclk_pkg::CNT_W_DEF);
    logic [CNT_W-1:0] PERIOD;
    logic [CNT_W-1:0] HIGH_WIDTH;
    logic [CNT_W-1:0] NCONV;
    logic             SET_PARAM;
    logic             START;
    logic             STOP;
    logic             CNVCLK_OUT;
    logic             CNV_STROBE;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] CONV_CNT;

    modport master (
        output PERIOD, HIGH_WIDTH, NCONV, SET_PARAM, START, STOP,
        input  CNVCLK_OUT, CNV_STROBE, BUSY, DONE, CONV_CNT
    );

    modport slave (
        input  PERIOD, HIGH_WIDTH, NCONV, SET_PARAM, START, STOP,
        output CNVCLK_OUT, CNV_STROBE, BUSY, DONE, CONV_CNT
    );
endinterface

// File: rtl/cnvclk_generator_param_shadow.sv
// Clamps and holds the active period/high/burst settings; updates requested
// while running are parked in pending registers until the next period wrap.
module cnvclk_param_shadow
    import cnvclk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [CNT_W-1:0] i_period,
    input  logic [CNT_W-1:0] i_high,
    input  logic [CNT_W-1:0] i_nconv,
    input  logic             i_set,
    input  logic             i_running,
    input  logic             i_apply,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic [CNT_W-1:0] o_nconv_start
);
    logic [CNT_W-1:0] w_p_eff;
    logic [CNT_W-1:0] w_h_eff;
    logic [CNT_W-1:0] r_act_period;
    logic [CNT_W-1:0] r_act_high;
    logic [CNT_W-1:0] r_act_nconv;
    logic [CNT_W-1:0] r_pend_period;
    logic [CNT_W-1:0] r_pend_high;
    logic [CNT_W-1:0] r_pend_nconv;
    logic             r_pend_flag;

    always_comb begin
        w_p_eff = (i_period < CNT_W'(2)) ? CNT_W'(2) : i_period;
        if (i_high == '0)
            w_h_eff = CNT_W'(1);
        else if (i_high >= w_p_eff)
            w_h_eff = w_p_eff - CNT_W'(1);
        else
            w_h_eff = i_high;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_act_period  <= CNT_W'(DEF_PERIOD);
            r_act_high    <= CNT_W'(DEF_HIGH);
            r_act_nconv   <= '0;
            r_pend_period <= '0;
            r_pend_high   <= '0;
            r_pend_nconv  <= '0;
            r_pend_flag   <= 1'b0;
        end else if (i_set && !i_running) begin
            r_act_period <= w_p_eff;
            r_act_high   <= w_h_eff;
            r_act_nconv  <= i_nconv;
            r_pend_flag  <= 1'b0;
        end else begin
            // A pending set left over from the exit cycle is flushed while idle.
            if ((i_apply || !i_running) && r_pend_flag) begin
                r_act_period <= r_pend_period;
                r_act_high   <= r_pend_high;
                r_act_nconv  <= r_pend_nconv;
                r_pend_flag  <= 1'b0;
            end
            if (i_set) begin
                r_pend_period <= w_p_eff;
                r_pend_high   <= w_h_eff;
                r_pend_nconv  <= i_nconv;
                r_pend_flag   <= 1'b1;
            end
        end
    end

    assign o_period      = r_act_period;
    assign o_high        = r_act_high;
    assign o_nconv_start = i_set ? i_nconv : r_act_nconv;
endmodule

// File: rtl/cnvclk_generator.sv
// ADC conversion-clock generator: run/stop FSM and phase counter producing a
// glitch-free registered CNVCLK, per-conversion strobe and conversion count.
module cnvclk_generator
    import cnvclk_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input logic     CLK_IN,
    input logic     RESET_N,
    cnvclk_if.slave bus
);
    //  state | meaning
    //  IDLE  | outputs low, waiting for START
    //  RUN   | phase counter cycling, CNVCLK active
    localparam logic [0:0] ST_IDLE = IDLE;
    localparam logic [0:0] ST_RUN  = RUN;

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_phase;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_target;
    logic             r_stop_req;
    logic             r_cnvclk;
    logic             r_strobe;
    logic             r_done;

    logic [CNT_W-1:0] w_period;
    logic [CNT_W-1:0] w_high;
    logic [CNT_W-1:0] w_nconv_start;
    logic [CNT_W-1:0] w_phase_inc;
    logic             w_run;
    logic             w_wrap;
    logic             w_exit;

    cnvclk_param_shadow #(.CNT_W(CNT_W)) u_shadow (
        .i_clk         (CLK_IN),
        .i_rst_n       (RESET_N),
        .i_period      (bus.PERIOD),
        .i_high        (bus.HIGH_WIDTH),
        .i_nconv       (bus.NCONV),
        .i_set         (bus.SET_PARAM),
        .i_running     (w_run),
        .i_apply       (w_run && w_wrap),
        .o_period      (w_period),
        .o_high        (w_high),
        .o_nconv_start (w_nconv_start)
    );

    assign w_run       = (r_state == ST_RUN);
    assign w_wrap      = (r_phase == w_period - CNT_W'(1));
    assign w_phase_inc = r_phase + CNT_W'(1);
    assign w_exit      = r_stop_req | bus.STOP |
                         ((r_target != '0) && (r_cnt == r_target));

    always_ff @(posedge CLK_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state    <= ST_IDLE;
            r_phase    <= '0;
            r_cnt      <= '0;
            r_target   <= '0;
            r_stop_req <= 1'b0;
            r_cnvclk   <= 1'b0;
            r_strobe   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.START && !bus.STOP) begin
                        r_state    <= ST_RUN;
                        r_phase    <= '0;
                        r_cnvclk   <= 1'b1;
                        r_strobe   <= 1'b1;
                        r_cnt      <= CNT_W'(1);
                        r_target   <= w_nconv_start;
                        r_stop_req <= 1'b0;
                    end
                end
                default: begin
                    if (bus.STOP)
                        r_stop_req <= 1'b1;
                    if (w_wrap) begin
                        r_phase <= '0;
                        // Exits only at a wrap, so the final low phase is always full length.
                        if (w_exit) begin
                            r_state    <= ST_IDLE;
                            r_done     <= 1'b1;
                            r_cnvclk   <= 1'b0;
                            r_stop_req <= 1'b0;
                        end else begin
                            r_cnvclk <= 1'b1;
                            r_strobe <= 1'b1;
                            r_cnt    <= r_cnt + CNT_W'(1);
                        end
                    end else begin
                        r_phase  <= w_phase_inc;
                        r_cnvclk <= (w_phase_inc < w_high);
                    end
                end
            endcase
        end
    end

    assign bus.CNVCLK_OUT = r_cnvclk;
    assign bus.CNV_STROBE = r_strobe;
    assign bus.BUSY       = w_run;
    assign bus.DONE       = r_done;
    assign bus.CONV_CNT   = r_cnt;
endmodule

// File: tb/tb_cnvclk_generator.sv
// Directed bench for cnvclk_generator: cycle-by-cycle comparison of CNVCLK,
// strobe, count and busy against hand-derived period/high patterns.
module tb_cnvclk_generator;
    logic clk_sys = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    cnvclk_if #(.CNT_W(16)) bus ();

    cnvclk_generator #(.CNT_W(16)) dut (
        .CLK_IN  (clk_sys),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_params(input int p, input int h, input int n, input logic with_start);
        bus.PERIOD     = 16'(p);
        bus.HIGH_WIDTH = 16'(h);
        bus.NCONV      = 16'(n);
        bus.SET_PARAM  = 1'b1;
        bus.START      = with_start;
        tick();
        bus.SET_PARAM  = 1'b0;
        bus.START      = 1'b0;
    endtask

    task automatic start_run();
        bus.START = 1'b1;
        tick();
        bus.START = 1'b0;
    endtask

    // Starts at the first RUN cycle (k=0); STOP/START are pulsed during cycle stop_k/start_k.
    task automatic run_periods(input string tag, input int p, input int h, input int nper,
                               input int stop_k, input int start_k);
        for (int k = 0; k < p * nper; k++) begin
            check_val($sformatf("%s cnvclk k=%0d", tag, k), 32'(bus.CNVCLK_OUT), 32'((k % p) < h));
            check_val($sformatf("%s strobe k=%0d", tag, k), 32'(bus.CNV_STROBE), 32'((k % p) == 0));
            check_val($sformatf("%s cnt k=%0d", tag, k), 32'(bus.CONV_CNT), 32'(k / p + 1));
            check_val($sformatf("%s busy k=%0d", tag, k), 32'(bus.BUSY), 32'd1);
            bus.STOP  = (k == stop_k);
            bus.START = (k == start_k);
            tick();
        end
        bus.STOP  = 1'b0;
        bus.START = 1'b0;
    endtask

    task automatic check_end(input string tag, input int cnt);
        check_val({tag, " done"}, 32'(bus.DONE), 32'd1);
        check_val({tag, " busy_end"}, 32'(bus.BUSY), 32'd0);
        check_val({tag, " cnt_end"}, 32'(bus.CONV_CNT), 32'(cnt));
        check_val({tag, " cnvclk_end"}, 32'(bus.CNVCLK_OUT), 32'd0);
        tick();
        check_val({tag, " done_pulse"}, 32'(bus.DONE), 32'd0);
        check_val({tag, " cnt_hold"}, 32'(bus.CONV_CNT), 32'(cnt));
    endtask

    initial begin
        int ph;
        int hh;
        int exp_cnt;
        rst_n          = 1'b0;
        bus.PERIOD     = '0;
        bus.HIGH_WIDTH = '0;
        bus.NCONV      = '0;
        bus.SET_PARAM  = 1'b0;
        bus.START      = 1'b0;
        bus.STOP       = 1'b0;
        #22;
        check_val("rst cnvclk", 32'(bus.CNVCLK_OUT), 32'd0);
        check_val("rst strobe", 32'(bus.CNV_STROBE), 32'd0);
        check_val("rst busy", 32'(bus.BUSY), 32'd0);
        check_val("rst done", 32'(bus.DONE), 32'd0);
        check_val("rst cnt", 32'(bus.CONV_CNT), 32'd0);
        rst_n = 1'b1;
        tick();

        // Basic burst: 10-cycle period, 3 high, 4 conversions.
        set_params(10, 3, 4, 1'b0);
        start_run();
        run_periods("burst", 10, 3, 4, -1, -1);
        check_end("burst", 4);

        // Clamp: period 1 -> 2, high 0 -> 1.
        set_params(1, 0, 2, 1'b0);
        start_run();
        run_periods("clamp_a", 2, 1, 2, -1, -1);
        check_end("clamp_a", 2);

        // Clamp high >= period -> period-1, with START on the SET_PARAM cycle.
        set_params(5, 9, 1, 1'b1);
        run_periods("clamp_b", 5, 4, 1, -1, -1);
        check_end("clamp_b", 1);

        // Continuous, STOP during phase 2 of the 6th period.
        set_params(8, 4, 0, 1'b0);
        start_run();
        run_periods("cont", 8, 4, 6, 42, -1);
        check_end("cont", 6);

        // Mid-run parameter update: first period stays 10/3, then 20/5; burst target stays 3.
        set_params(10, 3, 3, 1'b0);
        start_run();
        for (int k = 0; k < 50; k++) begin
            ph      = (k < 10) ? k : (k - 10) % 20;
            hh      = (k < 10) ? 3 : 5;
            exp_cnt = (k < 10) ? 1 : 2 + (k - 10) / 20;
            check_val($sformatf("upd cnvclk k=%0d", k), 32'(bus.CNVCLK_OUT), 32'(ph < hh));
            check_val($sformatf("upd strobe k=%0d", k), 32'(bus.CNV_STROBE), 32'(ph == 0));
            check_val($sformatf("upd cnt k=%0d", k), 32'(bus.CONV_CNT), 32'(exp_cnt));
            if (k == 4) begin
                bus.PERIOD     = 16'd20;
                bus.HIGH_WIDTH = 16'd5;
                bus.NCONV      = 16'd1;
                bus.SET_PARAM  = 1'b1;
            end else begin
                bus.SET_PARAM  = 1'b0;
            end
            tick();
        end
        bus.SET_PARAM = 1'b0;
        check_end("upd", 3);

        // START together with STOP in IDLE is refused.
        bus.START = 1'b1;
        bus.STOP  = 1'b1;
        tick();
        bus.START = 1'b0;
        bus.STOP  = 1'b0;
        check_val("ss busy", 32'(bus.BUSY), 32'd0);
        check_val("ss done", 32'(bus.DONE), 32'd0);
        check_val("ss cnvclk", 32'(bus.CNVCLK_OUT), 32'd0);
        tick();
        check_val("ss busy2", 32'(bus.BUSY), 32'd0);
        check_val("ss done2", 32'(bus.DONE), 32'd0);

        // START during RUN leaves phase and count untouched.
        set_params(6, 2, 3, 1'b0);
        start_run();
        run_periods("restart", 6, 2, 3, -1, 3);
        check_end("restart", 3);

        // Async reset at phase 1, then a run on the reset-default parameters (100/50, continuous).
        start_run();
        tick();
        check_val("rst_mid cnvclk_pre", 32'(bus.CNVCLK_OUT), 32'd1);
        rst_n = 1'b0;
        #1;
        check_val("rst_mid cnvclk", 32'(bus.CNVCLK_OUT), 32'd0);
        check_val("rst_mid busy", 32'(bus.BUSY), 32'd0);
        check_val("rst_mid cnt", 32'(bus.CONV_CNT), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        start_run();
        run_periods("post_rst", 100, 50, 2, 150, -1);
        check_end("post_rst", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
